// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the parity FSM: captures a word on a rising
// start level, shifts it out LSB first and optionally appends an even-parity bit.
module bit_serializer #(
    parameter int NBITS     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NBITS-1:0]           data_in,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NBITS+1)-1:0] ones_count
);

    localparam int CW = $clog2(NBITS + 1);
    localparam int IW = $clog2(NBITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] shreg;
    logic             par;
    logic [IW-1:0]    idx;
    logic             start_q;
    logic             start_edge;

    assign start_edge = start & ~start_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state defaults to the current one first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start_edge) state_next = SHIFT;
            SHIFT:  if (idx == IW'(NBITS - 1)) state_next = PARITY_EN ? PARITY : DONE;
            PARITY: state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // start_q resets high so a switch held on through reset cannot launch a frame.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            start_q    <= 1'b1;
            shreg      <= '0;
            par        <= 1'b0;
            idx        <= '0;
            ones_count <= '0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        shreg      <= data_in;
                        par        <= ^data_in;
                        idx        <= '0;
                        ones_count <= '0;
                    end
                end
                SHIFT: begin
                    shreg      <= shreg >> 1;
                    idx        <= idx + IW'(1);
                    ones_count <= ones_count + CW'(shreg[0]);
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; bit_out stays 0 outside a frame so the parity FSM holds still.
    always_comb begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            SHIFT: begin
                bit_out   = shreg[0];
                bit_valid = 1'b1;
            end
            PARITY: begin
                bit_out   = par;
                bit_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
